// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path.
// Used by multicycle_controller, ctrl_opdecode and the interface.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Data-memory request/ready handshake between the controller and data memory.
// The controller holds mem_read/mem_write stable until it samples mem_ready=1 on a rising clk.
interface multicycle_controller_if;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_read, output mem_write, input mem_ready);
    modport slave  (input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational opcode-to-instruction-class map for the control FSM.
module ctrl_opdecode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] op_i,
    output iclass_e    cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (op_i)
            OP_RTYPE: cls_o = CLS_RTYPE;
            OP_ADDI:  cls_o = CLS_ADDI;
            OP_LW:    cls_o = CLS_LOAD;
            OP_SW:    cls_o = CLS_STORE;
            OP_BEQ:   cls_o = CLS_BRANCH;
            OP_BNE:   cls_o = CLS_BRANCH;
            OP_J:     cls_o = CLS_JUMP;
            OP_HALT:  cls_o = CLS_HALT;
            default:  cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit CPU.
// Define MULTICYCLE_PERF_CNT_EN to build the 32-bit retired-instruction counter.
module multicycle_controller
    import cpu_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    input  logic [3:0]                     opcode,
    input  logic                           zero,
    multicycle_controller_if.master        dmem,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic [1:0]                     pc_src,
    output logic                           alu_src,
    output logic [2:0]                     alu_op,
    output logic                           reg_dst,
    output logic                           mem_to_reg,
    output logic                           reg_write,
    output logic                           halted,
    output logic                           illegal,
    output logic [31:0]                    retired,
    output state_e                         dbg_state
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       done;
    logic [3:0] dec_op;
    iclass_e    cls;

    // In DECODE the IR is fresh but op_q is not yet loaded, so classify the live opcode.
    assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

    ctrl_opdecode u_opdecode (
        .op_i  (dec_op),
        .cls_o (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 4'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        illegal_d      = illegal_q;
        done           = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PC_INC;
        alu_src        = 1'b0;
        alu_op         = ALU_ADD;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        reg_write      = 1'b0;
        halted         = 1'b0;
        dmem.mem_read  = 1'b0;
        dmem.mem_write = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_INC;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                op_d = opcode;
                case (cls)
                    CLS_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        done     = 1'b1;
                    end
                    CLS_HALT:    state_d = ST_HALT;
                    CLS_ILLEGAL: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls)
                    CLS_RTYPE: begin
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    CLS_ADDI: begin
                        alu_src = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BR;
                        pc_write = (op_q == OP_BNE) ? !zero : zero;
                        done     = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                // Address stays valid for the whole access, however long memory stalls.
                alu_src        = 1'b1;
                dmem.mem_read  = (cls == CLS_LOAD);
                dmem.mem_write = (cls == CLS_STORE);
                if (dmem.mem_ready) begin
                    if (cls == CLS_LOAD) state_d = ST_WB;
                    else                 done    = 1'b1;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls == CLS_RTYPE);
                mem_to_reg = (cls == CLS_LOAD);
                done       = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) state_d = run ? ST_FETCH : ST_IDLE;
    end

    assign illegal   = illegal_q;
    assign dbg_state = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;

    assign retired_d = done ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= 32'd0;
        else     retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: cycle-by-cycle outputs checked against a
// per-instruction step model; retired count modelled as "instructions completed so far".
module tb_multicycle_controller;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        zero = 1'b0;
    logic        ir_write, pc_write, alu_src, reg_dst, mem_to_reg, reg_write, halted, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [31:0] retired;
    state_e      dbg_state;

    multicycle_controller_if dmem_if ();

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .dmem       (dmem_if.master),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DEC = 2, PH_EXE = 3, PH_MEM = 4, PH_WB = 5, PH_HALT = 6;
`ifdef MULTICYCLE_PERF_CNT_EN
    localparam logic [31:0] RET_FINAL = 32'd3;
`else
    localparam logic [31:0] RET_FINAL = 32'd0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ret_model = 0;
    logic [46:0] exp_q[$];

    // Output vector: ir_write pc_write pc_src alu_src alu_op reg_dst mem_to_reg reg_write mem_read mem_write halted illegal
    function automatic logic [14:0] expect_out(input int ph, input logic [3:0] op, input logic z, input logic ill);
        logic       ir, pw, as, rd, m2r, rw, mr, mw, h;
        logic [1:0] ps;
        logic [2:0] ao;
        {ir, pw, as, rd, m2r, rw, mr, mw, h} = '0;
        ps = 2'b00;
        ao = 3'b000;
        case (ph)
            PH_FETCH: begin ir = 1'b1; pw = 1'b1; end
            PH_DEC:   if (op == 4'h6) begin pw = 1'b1; ps = 2'b10; end
            PH_EXE: begin
                if (op == 4'h0) ao = 3'b010;
                else if (op >= 4'h1 && op <= 4'h3) as = 1'b1;
                else if (op == 4'h4 || op == 4'h5) begin
                    ao = 3'b001;
                    ps = 2'b01;
                    pw = (op == 4'h4) ? z : !z;
                end
            end
            PH_MEM:  begin as = 1'b1; mr = (op == 4'h2); mw = (op == 4'h3); end
            PH_WB:   begin rw = 1'b1; rd = (op == 4'h0); m2r = (op == 4'h2); end
            PH_HALT: h = 1'b1;
            default: ;
        endcase
        return {ir, pw, ps, as, ao, rd, m2r, rw, mr, mw, h, ill};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {ir_write, pc_write, pc_src, alu_src, alu_op, reg_dst, mem_to_reg, reg_write,
                dmem_if.mem_read, dmem_if.mem_write, halted, illegal};
    endfunction

    function automatic logic [31:0] cur_ret();
`ifdef MULTICYCLE_PERF_CNT_EN
        return 32'(ret_model);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Compare process: one expected entry per driven cycle, sampled mid low-phase.
    always @(negedge clk) begin
        logic [46:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", 64'(dut_vec()), 64'(e[14:0]));
            check("retired", 64'(retired), 64'(e[46:15]));
        end
    end

    task automatic cycle(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                         input int ph, input logic ill);
        @(negedge clk);
        run = r;
        opcode = op;
        zero = z;
        dmem_if.mem_ready = rdy;
        exp_q.push_back({cur_ret(), expect_out(ph, op, z, ill)});
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(i == n - 1, 4'h0, rnd(), rnd(), PH_IDLE, 1'b0);
    endtask

    task automatic halt_cycles(input int n, input logic ill);
        for (int i = 0; i < n; i++) cycle(rnd(), 4'($urandom_range(0, 15)), rnd(), rnd(), PH_HALT, ill);
    endtask

    // One instruction from FETCH to completion; run_end is run during the completion cycle.
    task automatic do_instr(input logic [3:0] op, input logic z, input int waits,
                            input logic run_end, input int exp_len);
        int n = 0;
        cycle(rnd(), op, z, rnd(), PH_FETCH, 1'b0); n++;
        if (op == 4'h6) begin
            cycle(run_end, op, z, rnd(), PH_DEC, 1'b0); n++;
            ret_model++;
        end else if (op > 4'h6) begin
            cycle(rnd(), op, z, rnd(), PH_DEC, 1'b0); n++;
        end else begin
            cycle(rnd(), op, z, rnd(), PH_DEC, 1'b0); n++;
            if (op == 4'h4 || op == 4'h5) begin
                cycle(run_end, op, z, rnd(), PH_EXE, 1'b0); n++;
            end else if (op == 4'h2 || op == 4'h3) begin
                cycle(rnd(), op, z, rnd(), PH_EXE, 1'b0); n++;
                for (int i = 0; i < waits; i++) begin
                    cycle(rnd(), op, z, 1'b0, PH_MEM, 1'b0); n++;
                end
                cycle((op == 4'h3) ? run_end : rnd(), op, z, 1'b1, PH_MEM, 1'b0); n++;
                if (op == 4'h2) begin
                    cycle(run_end, op, z, rnd(), PH_WB, 1'b0); n++;
                end
            end else begin
                cycle(rnd(), op, z, rnd(), PH_EXE, 1'b0); n++;
                cycle(run_end, op, z, rnd(), PH_WB, 1'b0); n++;
            end
            ret_model++;
        end
        check($sformatf("cycles_op%0h", op), 64'(n), 64'(exp_len));
    endtask

    initial begin
        dmem_if.mem_ready = 1'b0;
        // Reset held: all outputs low.
        cycle(1'b0, 4'h0, 1'b0, 1'b0, PH_IDLE, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, PH_IDLE, 1'b0);
        #1 rst = 1'b0;

        idle(6);
        do_instr(4'h0, 1'b0, 0, 1'b1, 4);
        do_instr(4'h2, 1'b0, 3, 1'b1, 8);
        do_instr(4'h3, 1'b1, 0, 1'b1, 4);
        do_instr(4'h4, 1'b1, 0, 1'b1, 3);
        do_instr(4'h4, 1'b0, 0, 1'b1, 3);
        do_instr(4'h5, 1'b1, 0, 1'b1, 3);
        do_instr(4'h5, 1'b0, 0, 1'b1, 3);
        do_instr(4'h6, 1'b0, 0, 1'b1, 2);
        do_instr(4'h2, 1'b1, 0, 1'b1, 5);
        do_instr(4'h1, 1'b0, 0, 1'b0, 4);
        idle(3);
        do_instr(4'hB, 1'b0, 0, 1'b1, 2);
        halt_cycles(20, 1'b1);

        // Async reset while halted clears halted/illegal immediately.
        #3 rst = 1'b1;
        #1;
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        run = 1'b0;
        rst = 1'b0;
        ret_model = 0;

        // LW cut short by reset in the middle of its memory stall.
        idle(2);
        cycle(1'b1, 4'h2, 1'b0, 1'b1, PH_FETCH, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b1, PH_DEC, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b1, PH_EXE, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, PH_MEM, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, PH_MEM, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("rst_mem_read", 64'(dmem_if.mem_read), 64'd0);
        check("rst_mem_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_retired", 64'(retired), 64'd0);
        run = 1'b0;
        rst = 1'b0;

        idle(2);
        do_instr(4'h1, 1'b0, 0, 1'b1, 4);
        do_instr(4'h3, 1'b0, 0, 1'b1, 4);
        do_instr(4'h4, 1'b1, 0, 1'b1, 3);
        do_instr(4'hF, 1'b0, 0, 1'b1, 2);
        halt_cycles(5, 1'b0);
        @(negedge clk);
        #3;
        check("retired_final", 64'(retired), 64'(RET_FINAL));
        check("halted_final", 64'(halted), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
